// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM state type, SREG bit positions and op decode helpers for alu_mulseq
package alu_pkg;
   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULS   = 3'd1;
   localparam logic [2:0] OP_MULSU  = 3'd2;
   localparam logic [2:0] OP_FMUL   = 3'd3;
   localparam logic [2:0] OP_FMULS  = 3'd4;
   localparam logic [2:0] OP_FMULSU = 3'd5;
   localparam int SREG_C = 0;
   localparam int SREG_Z = 1;
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
   function automatic logic d_signed(input logic [2:0] op);
      return op inside {OP_MULS, OP_MULSU, OP_FMULS, OP_FMULSU};
   endfunction
   function automatic logic r_signed(input logic [2:0] op);
      return op inside {OP_MULS, OP_FMULS};
   endfunction
   function automatic logic is_fmul(input logic [2:0] op);
      return op inside {OP_FMUL, OP_FMULS, OP_FMULSU};
   endfunction
   function automatic logic is_rsvd(input logic [2:0] op);
      return op > OP_FMULSU;
   endfunction
endpackage

// File: rtl/alu_mulseq_core.sv
// alu_mulseq_core: unsigned shift-add multiplier, one multiplier bit per step, LSB first
// ports: clock, rst_n (sync, active-low), load (latch a/b, clear acc/counter), step (one iteration),
//        a/b magnitudes in, prod accumulator out, last (counter at WIDTH-1)
module alu_mulseq_core #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] prod,
   output logic               last
);
   localparam int CW = $clog2(WIDTH);
   logic [2*WIDTH-1:0] mcd;
   logic [WIDTH-1:0]   mpl;
   logic [CW-1:0]      cnt;
   assign last = cnt == CW'(WIDTH - 1);
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         prod <= '0;
         mcd  <= '0;
         mpl  <= '0;
         cnt  <= '0;
      end else if (load) begin
         prod <= '0;
         mcd  <= {{WIDTH{1'b0}}, a};
         mpl  <= b;
         cnt  <= '0;
      end else if (step) begin
         prod <= prod + (mpl[0] ? mcd : '0);
         mcd  <= mcd << 1;
         mpl  <= mpl >> 1;
         cnt  <= last ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/alu_mulseq.sv
// alu_mulseq: sequential AVR-style MUL/MULS/MULSU/FMUL/FMULS/FMULSU, fixed WIDTH+2 cycle latency
// ports: clock, rst_n (sync, active-low), start/op/d/r/s_in request, busy/done status,
//        res product (2*WIDTH), s_out updated SREG (C bit0, Z bit1, bits 7..2 passed through)
module alu_mulseq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   d,
   input  logic [WIDTH-1:0]   r,
   input  logic [7:0]         s_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] res,
   output logic [7:0]         s_out
);
   state_t state, nxt;
   logic [2:0] op_q;
   logic neg_q;
   logic [7:0] s_q;
   logic accept, last, d_neg, r_neg;
   logic [WIDTH-1:0] mag_d, mag_r;
   logic [2*WIDTH-1:0] prod, sprod, fprod;
   assign accept = state == S_IDLE && start;
   assign d_neg  = d_signed(op) && d[WIDTH-1];
   assign r_neg  = r_signed(op) && r[WIDTH-1];
   // the most negative value negates to itself, which read as unsigned is its exact magnitude
   assign mag_d  = d_neg ? -d : d;
   assign mag_r  = r_neg ? -r : r;
   assign sprod  = neg_q ? -prod : prod;
   assign fprod  = is_fmul(op_q) ? {sprod[2*WIDTH-2:0], 1'b0} : sprod;
   alu_mulseq_core #(.WIDTH(WIDTH)) u_core (
      .clock(clock),
      .rst_n(rst_n),
      .load (accept),
      .step (state == S_CALC),
      .a    (mag_d),
      .b    (mag_r),
      .prod (prod),
      .last (last)
   );
   always_ff @(posedge clock) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end
   always_comb begin
      nxt  = state;
      busy = state == S_CALC || state == S_FIX;
      done = state == S_DONE;
      unique case (state)
         S_IDLE:  nxt = start ? S_CALC : S_IDLE;
         S_CALC:  nxt = last ? S_FIX : S_CALC;
         S_FIX:   nxt = S_DONE;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         op_q  <= '0;
         neg_q <= 1'b0;
         s_q   <= '0;
         res   <= '0;
         s_out <= '0;
      end else begin
         if (accept) begin
            op_q  <= op;
            neg_q <= d_neg ^ r_neg;
            s_q   <= s_in;
         end
         if (state == S_FIX) begin
            res   <= is_rsvd(op_q) ? '0 : fprod;
            s_out <= s_q;
            if (!is_rsvd(op_q)) begin
               s_out[SREG_C] <= sprod[2*WIDTH-1];
               s_out[SREG_Z] <= fprod == '0;
            end
         end
      end
   end
endmodule

// File: doc/alu_mulseq.md
ALU_MULSEQ -- requirements
Module: alu_mulseq

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal values 4..16.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  0 MUL, 1 MULS, 2 MULSU, 3 FMUL, 4 FMULS, 5 FMULSU, 6/7 reserved.
REQ-006 d  input  WIDTH  first operand (Rd); signed for MULS/MULSU/FMULS/FMULSU.
REQ-007 r  input  WIDTH  second operand (Rr); signed for MULS/FMULS only.
REQ-008 s_in  input  8  SREG at start; bit0 C, bit1 Z.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse; res and s_out valid that cycle and held until next accept.
REQ-011 res  output  2*WIDTH  product (R1:R0 for WIDTH=8).
REQ-012 s_out  output  8  updated SREG.

Function
REQ-013 States IDLE, CALC, FIX, DONE; one-hot or binary encoding at implementer's choice.
REQ-014 IDLE: start=1 latches op, d, r, s_in; goes to CALC; busy=1 next cycle.
REQ-015 Signed operands converted to magnitude on latch; result sign = XOR of signs of operands treated as signed.
REQ-016 CALC: unsigned shift-add, one multiplier bit per cycle, LSB first, exactly WIDTH cycles, counter 0..WIDTH-1.
REQ-017 FIX: two's-complement negate 2*WIDTH-bit product if sign set; then for FMUL* shift left one, bit0=0.
REQ-018 C = bit 2*WIDTH-1 of signed/unsigned product before FMUL shift; Z = final res == 0; s_out bits 7..2 = latched s_in.
REQ-019 DONE: done=1, busy=0 for one cycle; next cycle IDLE.
REQ-020 Latency: start sampled at edge N -> done high in cycle N+WIDTH+2, fixed for all ops and operand values.
REQ-021 start while busy or done ignored; no queuing; operand changes after accept have no effect.
REQ-022 start in cycle following done accepted normally (back-to-back throughput WIDTH+3 cycles).
REQ-023 Reserved op: same latency, res=0, s_out=s_in.
REQ-024 Most-negative operand (0x80 at WIDTH=8) handled exactly; magnitude held in WIDTH+1 bits or unsigned-safe equivalent.

Reset
REQ-025 rst_n low at an edge: state IDLE, busy=0, done=0, res=0, s_out=0, counter=0.
REQ-026 Reset mid-operation aborts without done pulse; start in the first cycle with rst_n high is accepted.

Structure
REQ-027 Shared package alu_pkg holds op-code constants, state enum, SREG bit indices (C=0, Z=1).
REQ-028 One sub-module natural: alu_mulseq_core (shift-add datapath: accumulator, multiplier shift, counter); FSM and sign/FMUL fix-up in top.
REQ-029 No combinational path from inputs to outputs.

Verification
REQ-030 WIDTH=8, MUL d=0xFF r=0xFF -> res=0xFE01, C=1, Z=0, done at N+10.
REQ-031 MULS d=0x80 r=0x80 -> res=0x4000, C=0; MULSU d=0xFF r=0x02 -> res=0xFFFE, C=1.
REQ-032 FMUL d=0x80 r=0x80 -> res=0x8000, C=0; FMULS d=0x80 r=0x80 -> res=0x8000, C=0; MUL d=0x00 r=0x55 -> res=0, Z=1, C=0, s_out[7:2]=s_in[7:2].
REQ-033 start pulsed every cycle with changing operands during op -> exactly one done per accept, results match first-latched operands.
REQ-034 rst_n low at CALC cycle 3 -> no done, outputs zero; start next cycle -> correct result at N+10.
REQ-035 WIDTH=4, MUL d=0xF r=0xF -> res=0xE1, C=1, done at N+6; random sweep against reference model for all six ops.
